// File: rtl/axi_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : axi_arb_pkg
// Description : Shared types and helpers for the AXI address-channel QoS
//               arbiters: default QoS width, arbiter FSM state encoding and
//               the effective-priority builder (starvation bit above QoS).
// Revision    : 1.0 - initial release
// ============================================================================
package axi_arb_pkg;

   // Default width of a master's QoS field.
   localparam int c_QOS_W_DEFAULT = 4;

   // Widest QoS field the priority helper accepts. Narrower QoS values are
   // zero-extended into it, which preserves their ordering.
   localparam int c_PRIO_QOS_MAX_W = 16;
   localparam int c_PRIO_W         = c_PRIO_QOS_MAX_W + 1;

   typedef enum logic [0:0] {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_e;

   // A starved master outranks every non-starved master regardless of QoS.
   function automatic logic [c_PRIO_W-1:0] eff_prio(
      input logic                        saturated,
      input logic [c_PRIO_QOS_MAX_W-1:0] qos
   );
      return {saturated, qos};
   endfunction

endpackage : axi_arb_pkg
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_rr_pick
// Description : Combinational round-robin picker. Returns the first set bit
//               of the eligible mask at or above rr_ptr, wrapping to index 0.
// Ports       : eligible_i - candidate mask (bit i = master i)
//               rr_ptr_i   - search start index (< NUM_MASTERS)
//               idx_o      - selected index (valid when found_o = 1)
//               found_o    - at least one eligible bit was set
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rr_pick #(
   parameter int NUM_MASTERS = 4,
   parameter int ID_W        = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] eligible_i,
   input  logic [ID_W-1:0]        rr_ptr_i,
   output logic [ID_W-1:0]        idx_o,
   output logic                   found_o
);

   // Two passes: the upper pass covers [rr_ptr, N-1], the wrap pass covers
   // [0, N-1] and only matters when the upper pass found nothing.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found_o && eligible_i[i] && (ID_W'(i) >= rr_ptr_i)) begin
            idx_o   = ID_W'(i);
            found_o = 1'b1;
         end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (!found_o && eligible_i[i]) begin
            idx_o   = ID_W'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/axi_qos_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_qos_rr_arbiter
// Description : N-master QoS arbiter for an AXI AR/AW channel. Highest
//               effective priority wins, ties are broken round-robin, and
//               per-master age counters lift starved masters above all
//               others. The grant is registered and held until the
//               downstream address handshake completes.
// Ports       : ACLK, ARESETN    - clock, async active-low reset
//               req_valid_i      - per-master address valid
//               req_qos_i        - per-master QoS, master i at [i*QOS_W +: QOS_W]
//               token_i          - blocks issuing new grants
//               grant_accept_i   - downstream handshake completed this cycle
//               grant_valid_o    - a grant is held
//               grant_id_o       - index of granted master
//               grant_onehot_o   - one-hot grant, zero when no grant
//               starve_flag_o    - per-master age counter saturated
// Revision    : 1.0 - initial release
// ============================================================================
module axi_qos_rr_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_MASTERS = 4,
   parameter int QOS_W       = c_QOS_W_DEFAULT,
   parameter int AGE_W       = 4,
   parameter int ID_W        = $clog2(NUM_MASTERS)
) (
   input  logic                         ACLK,
   input  logic                         ARESETN,
   input  logic [NUM_MASTERS-1:0]       req_valid_i,
   input  logic [NUM_MASTERS*QOS_W-1:0] req_qos_i,
   input  logic                         token_i,
   input  logic                         grant_accept_i,
   output logic                         grant_valid_o,
   output logic [ID_W-1:0]              grant_id_o,
   output logic [NUM_MASTERS-1:0]       grant_onehot_o,
   output logic [NUM_MASTERS-1:0]       starve_flag_o
);

   localparam logic [AGE_W-1:0] c_AGE_MAX = '1;
   localparam logic [ID_W-1:0]  c_LAST_ID = ID_W'(NUM_MASTERS - 1);

   arb_state_e              state_q;
   logic                    grant_valid_q;
   logic [ID_W-1:0]         grant_id_q;
   logic [NUM_MASTERS-1:0]  grant_onehot_q;
   logic [ID_W-1:0]         rr_ptr_q;
   logic [AGE_W-1:0]        age_q [NUM_MASTERS];
   logic [AGE_W-1:0]        age_d [NUM_MASTERS];
   logic [NUM_MASTERS-1:0]  starve_q;

   logic [c_PRIO_W-1:0]     w_prio [NUM_MASTERS];
   logic [c_PRIO_W-1:0]     w_prio_max;
   logic [NUM_MASTERS-1:0]  w_eligible;
   logic [ID_W-1:0]         w_pick;
   logic                    w_found;

   // -------------------------------------------------------------------------
   // Effective priority. Invalid masters are forced to zero so the plain
   // maximum over all masters equals the maximum over valid ones; the
   // eligible mask still requires req_valid.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_prio
      logic [c_PRIO_QOS_MAX_W-1:0] w_qos_ext;

      always_comb begin
         w_qos_ext              = '0;
         w_qos_ext[QOS_W-1:0]   = req_qos_i[gi*QOS_W +: QOS_W];
      end

      assign w_prio[gi] = req_valid_i[gi] ? eff_prio(age_q[gi] == c_AGE_MAX, w_qos_ext)
                                          : '0;
   end

   always_comb begin
      w_prio_max = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (w_prio[i] > w_prio_max) begin
            w_prio_max = w_prio[i];
         end
      end
   end

   always_comb begin
      w_eligible = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_eligible[i] = req_valid_i[i] && (w_prio[i] == w_prio_max);
      end
   end

   arb_rr_pick #(
      .NUM_MASTERS (NUM_MASTERS),
      .ID_W        (ID_W)
   ) u_pick (
      .eligible_i  (w_eligible),
      .rr_ptr_i    (rr_ptr_q),
      .idx_o       (w_pick),
      .found_o     (w_found)
   );

   // -------------------------------------------------------------------------
   // Grant FSM. The selection is only evaluated in IDLE, so a held grant
   // cannot be pre-empted; returning to IDLE always costs one bubble cycle.
   // -------------------------------------------------------------------------
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q        <= ARB_IDLE;
         grant_valid_q  <= 1'b0;
         grant_id_q     <= '0;
         grant_onehot_q <= '0;
         rr_ptr_q       <= '0;
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (!token_i && w_found) begin
                  state_q        <= ARB_GRANT;
                  grant_valid_q  <= 1'b1;
                  grant_id_q     <= w_pick;
                  grant_onehot_q <= NUM_MASTERS'(1) << w_pick;
               end
            end
            ARB_GRANT: begin
               if (grant_accept_i) begin
                  state_q        <= ARB_IDLE;
                  grant_valid_q  <= 1'b0;
                  grant_onehot_q <= '0;
                  rr_ptr_q       <= (grant_id_q == c_LAST_ID) ? '0 : grant_id_q + 1'b1;
               end else if (!req_valid_i[grant_id_q]) begin
                  // Master withdrew its request: release without a handshake.
                  state_q        <= ARB_IDLE;
                  grant_valid_q  <= 1'b0;
                  grant_onehot_q <= '0;
               end
            end
            default: begin
               state_q        <= ARB_IDLE;
               grant_valid_q  <= 1'b0;
               grant_onehot_q <= '0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Age counters. A waiting master ages once per handshake it loses; idle
   // masters are reset while the arbiter is in IDLE.
   // -------------------------------------------------------------------------
   always_comb begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
         age_d[j] = age_q[j];
         if (state_q == ARB_IDLE) begin
            if (!req_valid_i[j]) begin
               age_d[j] = '0;
            end
         end else if (grant_accept_i) begin
            if (ID_W'(j) == grant_id_q) begin
               age_d[j] = '0;
            end else if (req_valid_i[j] && (age_q[j] != c_AGE_MAX)) begin
               age_d[j] = age_q[j] + 1'b1;
            end
         end
      end
   end

   // The flag is registered from the next-state age so it always mirrors
   // the counter value that the priority logic is using.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int j = 0; j < NUM_MASTERS; j++) begin
            age_q[j] <= '0;
         end
         starve_q <= '0;
      end else begin
         for (int j = 0; j < NUM_MASTERS; j++) begin
            age_q[j]    <= age_d[j];
            starve_q[j] <= (age_d[j] == c_AGE_MAX);
         end
      end
   end

   assign grant_valid_o  = grant_valid_q;
   assign grant_id_o     = grant_id_q;
   assign grant_onehot_o = grant_onehot_q;
   assign starve_flag_o  = starve_q;

endmodule : axi_qos_rr_arbiter
`default_nettype wire

// File: doc/axi_qos_rr_arbiter.md
Name: axi_qos_rr_arbiter

Overview:
N-master QoS arbiter for the interconnect's AXI read-address (or write-address) channel. It is the parametrised successor of the fixed 2-master QoS arbiter.
- Selects the highest-QoS requester.
- Breaks QoS ties round-robin instead of by fixed index.
- Boosts starved masters via per-master age counters.
- Holds a registered, locked grant until the downstream address handshake completes.
- Sits between the master-side AR/AW valid/qos inputs and the address mux/decoder.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
QOS_W, 4, width of each QoS field
AGE_W, 4, width of per-master age counter; starvation threshold = 2**AGE_W-1
ID_W, $clog2(NUM_MASTERS), width of grant_id

Ports:
ACLK  in  1  clock
ARESETN  in  1  reset, asynchronous, active-low
req_valid  in  NUM_MASTERS  per-master address valid (bit i = master i)
req_qos  in  NUM_MASTERS*QOS_W  per-master QoS, master i at [i*QOS_W +: QOS_W]
token  in  1  split-transaction hold; blocks issuing new grants
grant_accept  in  1  downstream handshake (selected valid && ready) completed this cycle
grant_valid  out  1  a grant is held
grant_id  out  ID_W  index of granted master
grant_onehot  out  NUM_MASTERS  one-hot of grant_id, all-zero when grant_valid=0
starve_flag  out  NUM_MASTERS  bit i = age counter i saturated

Behaviour:
- Reset values: grant_valid=0, grant_id=0, grant_onehot=0, starve_flag=0, rr_ptr=0, all age counters=0, FSM=IDLE.
- Effective priority of master i:
  - {1'b1, req_qos[i]} when age[i] is saturated, else {1'b0, req_qos[i]}.
  - Only computed when req_valid[i]=1.
- Selection: keep masters whose effective priority equals the maximum among valid masters. Among those, pick the first index at or after rr_ptr, searching upward with wrap-around.
- FSM states:
  - IDLE:
    - If token=0 and any req_valid, register the selection.
    - grant_valid=1 and grant_id/grant_onehot valid on the next edge; latency 1 cycle from request.
    - If token=1, stay in IDLE.
  - GRANT:
    - grant_id is stable and the selection is not re-evaluated, even if a higher-QoS request arrives.
    - If grant_accept=1: rr_ptr <= (grant_id+1) mod NUM_MASTERS, age[grant_id] <= 0, grant_valid <= 0, go to IDLE.
    - Else if req_valid[grant_id]=0 (protocol-violating withdraw): grant_valid <= 0, go to IDLE, rr_ptr and ages unchanged.
- A new grant can be issued on the cycle after the IDLE return at the earliest. There is exactly one bubble cycle of grant_valid=0 between consecutive grants.
- token asserted during GRANT does not revoke the held grant. It only blocks the next issue.
- grant_accept while in IDLE is ignored.
- Age counters:
  - On each cycle with grant_accept=1, every master j with req_valid[j]=1 and j != grant_id increments, saturating at 2**AGE_W-1.
  - A counter is cleared on its own accept, and when req_valid[j]=0 in IDLE.
  - starve_flag[j] is registered: (age[j] == max).
- Reset mid-grant: grant drops immediately (async); no handshake is completed.
- NUM_MASTERS not a power of two: rr_ptr wraps at NUM_MASTERS-1 → 0, and grant_id never exceeds NUM_MASTERS-1.

Decomposition:
- Package axi_arb_pkg holds:
  - the default QOS_W=4;
  - the FSM state enum (ARB_IDLE, ARB_GRANT);
  - the function for the effective-priority concatenation.
- One combinational sub-module, arb_rr_pick:
  - inputs: eligible mask, rr_ptr;
  - outputs: index, found.
  - It is reused by the write-address arbiter.
- The top level holds the max-priority masking, FSM, age counters and output registers.

Test Plan:
- NUM_MASTERS=4, only M2 valid with qos=3 → grant_valid=1, grant_id=2 one cycle later. Pulse grant_accept → grant_valid=0 next cycle, rr_ptr=3.
- All four valid with qos {M0=1, M1=7, M2=7, M3=2}, rr_ptr=0 → grants M1. After accept, the next grant after one bubble is M2, then M1 again (round-robin among qos=7).
- M0 qos=15 continuously plus M3 qos=0, AGE_W=2, grant_accept each grant → M3 age reaches 3 after 3 lost accepts, starve_flag[3]=1, next grant is M3 and age[3] clears to 0.
- In GRANT to M1, raise token and M0 qos=15 → grant_id stays 1 until accept. After accept, no new grant while token=1; grant issues 1 cycle after token falls.
- In GRANT to M2, drop req_valid[2] without accept → grant_valid=0 next cycle, rr_ptr and ages unchanged.
- NUM_MASTERS=3: assert ARESETN low mid-grant → outputs zero asynchronously. rr_ptr wrap test: accept on M2 → rr_ptr=0.
